// File: rtl/seven_seg_pkg.sv
// Shared types, segment patterns and anode helpers for the seven-segment scan decoder.
// Patterns are written a..g, MSB = segment a, active-low.
package seven_seg_pkg;

    localparam int CODE_W = 6;
    typedef logic [CODE_W-1:0] code_t;

    localparam code_t SEG_OFF     = 6'd16;
    localparam code_t SEG_DASH    = 6'd17;
    localparam code_t SEG_INVALID = 6'd63;

    localparam logic [6:0] PAT_0    = 7'b0000001;
    localparam logic [6:0] PAT_1    = 7'b1001111;
    localparam logic [6:0] PAT_2    = 7'b0010010;
    localparam logic [6:0] PAT_3    = 7'b0000110;
    localparam logic [6:0] PAT_4    = 7'b1001100;
    localparam logic [6:0] PAT_5    = 7'b0100100;
    localparam logic [6:0] PAT_6    = 7'b0100000;
    localparam logic [6:0] PAT_7    = 7'b0001111;
    localparam logic [6:0] PAT_8    = 7'b0000000;
    localparam logic [6:0] PAT_9    = 7'b0000100;
    localparam logic [6:0] PAT_A    = 7'b0001000;
    localparam logic [6:0] PAT_B    = 7'b1100000;
    localparam logic [6:0] PAT_C    = 7'b0110001;
    localparam logic [6:0] PAT_D    = 7'b1000010;
    localparam logic [6:0] PAT_E    = 7'b0110000;
    localparam logic [6:0] PAT_F    = 7'b0111000;
    localparam logic [6:0] PAT_OFF  = 7'b1111111;
    localparam logic [6:0] PAT_DASH = 7'b1111110;

    // True when exactly one anode is driven low.
    function automatic logic one_low(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to digit-code lookup.
// Unrecognized patterns map to SEG_INVALID and raise o_invalid.
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output code_t      o_code,
    output logic       o_invalid
);

    always_comb begin
        o_code    = SEG_INVALID;
        o_invalid = 1'b0;
        case (i_pattern)
            PAT_0:    o_code = 6'd0;
            PAT_1:    o_code = 6'd1;
            PAT_2:    o_code = 6'd2;
            PAT_3:    o_code = 6'd3;
            PAT_4:    o_code = 6'd4;
            PAT_5:    o_code = 6'd5;
            PAT_6:    o_code = 6'd6;
            PAT_7:    o_code = 6'd7;
            PAT_8:    o_code = 6'd8;
            PAT_9:    o_code = 6'd9;
            PAT_A:    o_code = 6'd10;
            PAT_B:    o_code = 6'd11;
            PAT_C:    o_code = 6'd12;
            PAT_D:    o_code = 6'd13;
            PAT_E:    o_code = 6'd14;
            PAT_F:    o_code = 6'd15;
            PAT_OFF:  o_code = SEG_OFF;
            PAT_DASH: o_code = SEG_DASH;
            default:  o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Receiver for a multiplexed active-low seven-segment bus: waits for each digit dwell
// to settle, decodes it into a shadow slot, and publishes all four codes per frame.
module seven_segment_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output code_t      digit0,
    output code_t      digit1,
    output code_t      digit2,
    output code_t      digit3,
    output logic       frame_valid,
    output logic       decode_err
);

    localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);

    logic [10:0]      r_sync1;
    logic [10:0]      r_s;
    logic [15:0]      r_cnt;
    logic             r_held;
    logic [3:0]       r_mask;
    code_t [3:0]      r_shadow;

    logic [15:0]      w_cnt_next;
    logic             w_capture;
    logic [1:0]       w_slot;
    code_t            w_code;
    logic             w_invalid;
    logic [3:0]       w_mask_next;
    logic             w_frame_done;
    code_t [3:0]      w_frame;

    // r_sync1 is the sample S takes on this edge; r_cnt always describes r_s, so the
    // count is evaluated against the incoming sample and capture lands on the edge
    // the count reaches its terminal value.
    always_comb begin
        w_cnt_next = '0;
        if ((r_sync1 == r_s) && one_low(r_sync1[10:7])) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 16'd1;
        end
    end

    assign w_capture    = (w_cnt_next == CNT_MAX) && !r_held;
    assign w_slot       = low_index(r_sync1[10:7]);
    assign w_mask_next  = r_mask | (4'b0001 << w_slot);
    assign w_frame_done = w_capture && (w_mask_next == 4'b1111);

    seg_pattern_decode u_decode (
        .i_pattern (r_sync1[6:0]),
        .o_code    (w_code),
        .o_invalid (w_invalid)
    );

    always_comb begin
        w_frame         = r_shadow;
        w_frame[w_slot] = w_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_s         <= '0;
            r_cnt       <= '0;
            r_held      <= 1'b0;
            r_mask      <= '0;
            r_shadow    <= {4{SEG_OFF}};
            digit0      <= SEG_OFF;
            digit1      <= SEG_OFF;
            digit2      <= SEG_OFF;
            digit3      <= SEG_OFF;
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
        end else begin
            r_sync1     <= {an, seg};
            r_s         <= r_sync1;
            r_cnt       <= w_cnt_next;
            frame_valid <= w_frame_done;
            decode_err  <= w_capture && w_invalid;

            if (w_cnt_next == '0) begin
                r_held <= 1'b0;
            end else if (w_capture) begin
                r_held <= 1'b1;
            end

            if (w_capture) begin
                r_shadow[w_slot] <= w_code;
                r_mask           <= w_frame_done ? 4'b0000 : w_mask_next;
            end

            if (w_frame_done) begin
                digit0 <= w_frame[0];
                digit1 <= w_frame[1];
                digit2 <= w_frame[2];
                digit3 <= w_frame[3];
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: directed scenarios plus randomized dwells,
// checked every cycle against a run-length reference model of the display bus.
module tb_seven_segment_scan_decoder;

    localparam int STABLE = 8;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_i;
    logic [3:0] an_i;
    logic [5:0] digit0, digit1, digit2, digit3;
    logic       frame_valid, decode_err;

    seven_segment_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg_i),
        .an          (an_i),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .frame_valid (frame_valid),
        .decode_err  (decode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int fv_cnt  = 0;
    int err_cnt = 0;

    logic [6:0] pat_tbl [18] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000,
                                 7'b1111111, 7'b1111110};

    // Reference model: pins seen one edge ago (m_p1), current sample, run length.
    logic [10:0] m_p1, m_s;
    int          m_run;
    logic [3:0]  m_mask;
    logic [5:0]  m_shadow [4];
    logic [5:0]  m_dig [4];
    logic        exp_fv, exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 18; i++) if (pat_tbl[i] == p) return 6'(i);
        return 6'd63;
    endfunction

    task automatic model_reset();
        m_p1 = '0; m_s = '0; m_run = 0; m_mask = '0;
        for (int i = 0; i < 4; i++) begin m_shadow[i] = 6'd16; m_dig[i] = 6'd16; end
        exp_fv = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model_edge();
        logic [10:0] s_new;
        logic        good;
        int          k;
        logic [5:0]  code;
        if (!rst_n) begin model_reset(); return; end
        exp_fv = 1'b0; exp_err = 1'b0;
        s_new = m_p1;
        m_p1  = {an_i, seg_i};
        good  = ($countones(~s_new[10:7]) == 1);
        if (good && s_new == m_s) m_run = (m_run > STABLE) ? m_run : m_run + 1;
        else                      m_run = good ? 1 : 0;
        m_s = s_new;
        if (m_run == STABLE) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (!s_new[7+i]) k = i;
            code = ref_decode(s_new[6:0]);
            m_shadow[k] = code;
            m_mask[k]   = 1'b1;
            exp_err     = (code == 6'd63);
            if (m_mask == 4'b1111) begin
                for (int i = 0; i < 4; i++) m_dig[i] = m_shadow[i];
                exp_fv = 1'b1;
                m_mask = '0;
            end
        end
    endtask

    // Drive pins at the falling edge, model the rising edge, check at the next falling edge.
    task automatic cycle(input logic [3:0] an, input logic [6:0] sg);
        an_i = an; seg_i = sg;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("frame_valid", {31'd0, frame_valid}, {31'd0, exp_fv});
        check("decode_err", {31'd0, decode_err}, {31'd0, exp_err});
        check("digits", {8'd0, digit3, digit2, digit1, digit0},
              {8'd0, m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
        fv_cnt  += int'(frame_valid);
        err_cnt += int'(decode_err);
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] sg, input int len);
        for (int i = 0; i < len; i++) cycle(an, sg);
    endtask

    function automatic logic [3:0] sel(input int k);
        logic [3:0] a;
        a = 4'b1111;
        a[k] = 1'b0;
        return a;
    endfunction

    initial begin
        rst_n = 1'b0; an_i = 4'b1111; seg_i = 7'b1111111;
        model_reset();
        @(negedge clk);
        dwell(4'b1111, 7'b1111111, 3);
        check("rst_digits", {8'd0, digit3, digit2, digit1, digit0}, {8'd0, {4{6'd16}}});
        rst_n = 1'b1;

        // Full frame 2,1,0,A
        fv_cnt = 0;
        dwell(sel(0), 7'b0010010, 20);
        dwell(sel(1), 7'b1001111, 20);
        dwell(sel(2), 7'b0000001, 20);
        dwell(sel(3), 7'b0001000, 20);
        check("ff_count", fv_cnt, 1);
        check("ff_digits", {8'd0, digit3, digit2, digit1, digit0}, {8'd0, 6'd10, 6'd0, 6'd1, 6'd2});

        // Short dwell on digit 2 is never captured
        fv_cnt = 0;
        dwell(sel(0), 7'b0100100, 15);
        dwell(sel(1), 7'b0100000, 15);
        dwell(sel(3), 7'b0001111, 15);
        dwell(sel(2), 7'b0000110, 6);
        dwell(4'b1111, 7'b0000000, 10);
        check("short_none", fv_cnt, 0);
        dwell(sel(2), 7'b0000110, 20);
        check("short_then", fv_cnt, 1);
        check("short_d2", {26'd0, digit2}, 32'd3);

        // OFF, DASH, invalid, 8
        fv_cnt = 0; err_cnt = 0;
        dwell(sel(0), 7'b1111111, 15);
        dwell(sel(1), 7'b1111110, 15);
        check("dash_noerr", err_cnt, 0);
        dwell(sel(2), 7'b1010101, 15);
        dwell(sel(3), 7'b0000000, 15);
        check("inv_err", err_cnt, 1);
        check("spec_digits", {8'd0, digit3, digit2, digit1, digit0}, {8'd0, 6'd8, 6'd63, 6'd17, 6'd16});

        // Blanking and multi-select between dwells
        fv_cnt = 0;
        dwell(sel(0), 7'b1001100, 15);
        dwell(4'b1111, 7'b0000000, 50);
        dwell(sel(1), 7'b1100000, 15);
        dwell(4'b1100, 7'b0000000, 50);
        dwell(sel(2), 7'b0110001, 15);
        dwell(sel(3), 7'b1000010, 15);
        check("blank_count", fv_cnt, 1);
        check("blank_digits", {8'd0, digit3, digit2, digit1, digit0}, {8'd0, 6'd13, 6'd12, 6'd11, 6'd4});

        // One-cycle glitch inside a dwell: latest capture wins
        dwell(sel(0), 7'b0000110, 12);
        dwell(sel(0), 7'b0001111, 1);
        dwell(sel(0), 7'b0100100, 12);
        dwell(sel(1), 7'b0110000, 15);
        dwell(sel(2), 7'b0111000, 15);
        dwell(sel(3), 7'b0000001, 15);
        check("glitch_d0", {26'd0, digit0}, 32'd5);

        // Overwrite of slot 0 before frame completes
        dwell(sel(0), 7'b0100100, 15);
        dwell(sel(1), 7'b0000001, 15);
        dwell(sel(2), 7'b0000001, 15);
        dwell(sel(0), 7'b0000100, 15);
        dwell(sel(3), 7'b0000001, 15);
        check("ovw_d0", {26'd0, digit0}, 32'd9);

        // Reset mid-count discards partial captures
        dwell(sel(0), 7'b0010010, 15);
        dwell(sel(1), 7'b0010010, 15);
        dwell(sel(2), 7'b0010010, 15);
        dwell(sel(3), 7'b0010010, 4);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_digits", {8'd0, digit3, digit2, digit1, digit0}, {8'd0, {4{6'd16}}});
        check("mid_rst_pulses", {30'd0, frame_valid, decode_err}, 32'd0);
        model_reset();
        dwell(sel(3), 7'b0010010, 3);
        rst_n = 1'b1;
        fv_cnt = 0;
        dwell(sel(3), 7'b0010010, 15);
        dwell(sel(0), 7'b0010010, 15);
        dwell(sel(1), 7'b0010010, 15);
        check("rst_nofv", fv_cnt, 0);

        // Randomized dwells
        for (int d = 0; d < 120; d++) begin
            int          r;
            logic [3:0]  a;
            logic [6:0]  s;
            logic [3:0]  multi;
            r = int'($urandom_range(0, 9));
            multi = 4'($urandom_range(0, 15));
            if (r == 6)      a = 4'b1111;
            else if (r == 7) a = ($countones(~multi) > 1) ? multi : 4'b0000;
            else             a = sel(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) != 0) s = pat_tbl[$urandom_range(0, 17)];
            else                           s = 7'($urandom);
            dwell(a, s, int'($urandom_range(1, 20)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
